// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - uart_state_e : serial engine states
//   - register offsets and the address bit that selects between them
//   - STATUS word bit positions
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [10:0] TXDATA_OFS = 11'h000;
  localparam logic [10:0] STATUS_OFS = 11'h004;

  // The two registers differ only in this byte-address bit.
  localparam int REG_SEL_BIT = 2;

  localparam int FULL_BIT  = 0;
  localparam int EMPTY_BIT = 1;
  localparam int BUSY_BIT  = 2;
  localparam int OVF_BIT   = 3;
  localparam int COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : enqueue din when push and (not full, or a pop happens this cycle)
//   pop, dout     : dout is the head entry; pop advances it (ignored when empty)
//   full, empty   : occupancy flags
//   count         : number of entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data-memory bus.
// Stores to TXDATA queue a byte; stores to STATUS clear the sticky overflow.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   sel, mem_write  : bus access targets this block / store strobe
//   addr, wdata     : byte address (only addr[2] decoded) / store data
//   rdata           : combinational read data (STATUS word, else 0)
//   tx              : registered serial output, idle high
//   busy            : frame in flight or bytes waiting
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); back-to-back start if another byte waits
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        mem_write,
  input  logic [10:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q;

  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          push_req;
  logic          ovf_clr;
  logic          baud_last;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{addr[10:3], addr[1:0], wdata[31:8]};

  assign push_req = sel & mem_write & ~addr[REG_SEL_BIT];
  assign ovf_clr  = sel & mem_write &  addr[REG_SEL_BIT];

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_req),
    .din  (wdata[7:0]),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_last ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_last) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          bit_d = '0;
          // Chain straight into the next start bit so queued bytes leave
          // with no idle-high gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // A dropped push needs full with no pop; fifo_pop only asserts when non-empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end else if (push_req && fifo_full && !fifo_pop) begin
      ovf_q <= 1'b1;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) | ~fifo_empty;

  always_comb begin
    status                   = '0;
    status[FULL_BIT]         = fifo_full;
    status[EMPTY_BIT]        = fifo_empty;
    status[BUSY_BIT]         = busy;
    status[OVF_BIT]          = ovf_q;
    status[COUNT_LSB +: CW]  = fifo_count;
  end

  assign rdata = (sel && addr[REG_SEL_BIT]) ? status : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        mem_write;
  logic [10:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: a byte queue plus the per-cycle line waveform of the
  // frame currently on the wire (wave[0] is the present tx level).
  logic [7:0] mq[$];
  bit         wave[$];
  bit         ovf_m = 1'b0;

  function automatic bit busy_m();
    return (wave.size() > 0) || (mq.size() > 0);
  endfunction

  function automatic bit tx_m();
    return (wave.size() > 0) ? wave[0] : 1'b1;
  endfunction

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s       = '0;
    s[0]    = (mq.size() == DEPTH);
    s[1]    = (mq.size() == 0);
    s[2]    = busy_m();
    s[3]    = ovf_m;
    s[11:8] = 4'(mq.size());
    return s;
  endfunction

  task automatic start_frame(input logic [7:0] b);
    for (int k = 0; k < CPB; k++) wave.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < CPB; k++) wave.push_back(b[i]);
    for (int k = 0; k < CPB; k++) wave.push_back(1'b1);
  endtask

  task automatic model_edge(input logic r, input logic s, input logic w,
                            input logic [10:0] a, input logic [31:0] d);
    bit popped;
    bit full_pre;
    if (r) begin
      mq.delete();
      wave.delete();
      ovf_m = 1'b0;
      return;
    end
    full_pre = (mq.size() == DEPTH);
    popped   = 1'b0;
    if (wave.size() > 1) begin
      void'(wave.pop_front());
    end else begin
      wave.delete();
      if (mq.size() > 0) begin
        start_frame(mq.pop_front());
        popped = 1'b1;
      end
    end
    if (s && w && !a[2]) begin
      if (!full_pre || popped) mq.push_back(d[7:0]);
      else ovf_m = 1'b1;
    end
    if (s && w && a[2]) ovf_m = 1'b0;
  endtask

  // One clock: drive inputs, check outputs at the falling edge against the
  // model's pre-edge state, then advance the model at the rising edge.
  task automatic step(input logic r, input logic s, input logic w,
                      input logic [10:0] a, input logic [31:0] d,
                      output logic [31:0] rd_obs);
    rst       = r;
    sel       = s;
    mem_write = w;
    addr      = a;
    wdata     = d;
    @(negedge clk);
    rd_obs = rdata;
    check("rdata", rdata, (s && a[2]) ? status_m() : 32'h0);
    check("tx",    {31'b0, tx},   {31'b0, tx_m()});
    check("busy",  {31'b0, busy}, {31'b0, busy_m()});
    @(posedge clk);
    model_edge(r, s, w, a, d);
    #1;
  endtask

  logic [31:0] rd;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 11'h0, 32'h0, rd);
  endtask

  task automatic push(input logic [7:0] b);
    step(1'b0, 1'b1, 1'b1, 11'h000, {24'hABCDEF, b}, rd);
  endtask

  task automatic read_status();
    step(1'b0, 1'b1, 1'b0, 11'h004, 32'h0, rd);
  endtask

  initial begin
    // Reset and idle status.
    step(1'b1, 1'b0, 1'b0, 11'h0, 32'h0, rd);
    step(1'b1, 1'b0, 1'b0, 11'h0, 32'h0, rd);
    read_status();
    check("reset_status", rd, 32'h0000_0002);
    check("reset_tx", {31'b0, tx}, 32'h1);

    // Single frame.
    push(8'h55);
    idle(44);
    read_status();
    check("single_done", rd, 32'h0000_0002);

    // Three back-to-back frames.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    idle(124);
    read_status();
    check("triple_done", rd, 32'h0000_0002);

    // Overflow: ten consecutive stores, nine accepted.
    for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
    read_status();
    check("ovf_status", rd, 32'h0000_080D);
    step(1'b0, 1'b1, 1'b1, 11'h004, 32'hFFFF_FFFF, rd);
    read_status();
    check("ovf_clear", rd & 32'h8, 32'h0);
    idle(9 * 10 * CPB + 4);
    read_status();
    check("ovf_drained", rd, 32'h0000_0002);

    // Reset in the middle of a data bit with bytes still queued.
    push(8'hA5);
    push(8'h3C);
    push(8'h7E);
    idle(15);
    step(1'b1, 1'b0, 1'b0, 11'h0, 32'h0, rd);
    read_status();
    check("midrst_status", rd, 32'h0000_0002);
    check("midrst_tx", {31'b0, tx}, 32'h1);
    idle(60);

    // Ignored accesses.
    step(1'b0, 1'b0, 1'b1, 11'h000, 32'h0000_00FF, rd);
    check("nosel_rd", rd, 32'h0);
    step(1'b0, 1'b0, 1'b1, 11'h004, 32'h0000_00FF, rd);
    check("nosel_status_rd", rd, 32'h0);
    step(1'b0, 1'b1, 1'b0, 11'h000, 32'h0000_00FF, rd);
    check("txdata_rd", rd, 32'h0);
    read_status();
    check("ignored_status", rd, 32'h0000_0002);
    check("ignored_tx", {31'b0, tx}, 32'h1);

    // Randomized bus traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      int unsigned r;
      logic [10:0] a;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      a = 11'($urandom);
      d = $urandom;
      if (r < 1)       step(1'b1, 1'($urandom), 1'($urandom), a, d, rd);
      else if (r < 9)  step(1'b0, 1'b1, 1'b1, {a[10:3], 1'b0, a[1:0]}, d, rd);
      else if (r < 12) step(1'b0, 1'b1, 1'b1, {a[10:3], 1'b1, a[1:0]}, d, rd);
      else if (r < 30) step(1'b0, 1'b1, 1'b0, {a[10:3], 1'b1, a[1:0]}, d, rd);
      else if (r < 40) step(1'b0, 1'b0, 1'b1, a, d, rd);
      else if (r < 50) step(1'b0, 1'b1, 1'b0, {a[10:3], 1'b0, a[1:0]}, d, rd);
      else             step(1'b0, 1'b0, 1'b0, a, d, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the single-cycle CPU's data-memory bus, downstream of the CPU alongside dmem.
- Store traffic decoded to this block pushes bytes into an internal FIFO.
- A serial engine drains the FIFO onto `tx` as 8N1 frames.
- The CPU polls a status word through the same bus read path.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 8: byte FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  1  top-level address decode: this bus access targets the UART.
- mem_write  in  1  store strobe from the CPU.
- addr  in  11  byte address from the CPU; only addr[2] is decoded (0 = TXDATA, 1 = STATUS).
- wdata  in  32  store data; TXDATA uses wdata[7:0].
- rdata  out  32  combinational read data.
- tx  out  1  serial line, registered, idle high.
- busy  out  1  high while a frame is in flight or the FIFO is non-empty.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - tx=1, state IDLE, FIFO empty, bit/baud counters 0, overflow flag 0.
  - rdata for STATUS reads 32'h0000_0002; busy=0.
  - Applies mid-frame: tx returns high at that edge and FIFO contents are discarded.
- Push:
  - Condition: sel & mem_write & ~addr[2] sampled at edge E.
  - If FIFO not full, wdata[7:0] is enqueued at E.
  - If full and no pop at E, the byte is dropped and overflow is set (sticky).
  - If full and a pop occurs at E, the push is accepted and count is unchanged.
- Overflow clear: sel & mem_write & addr[2] clears overflow; no other effect.
- STATUS word:
  - bit0 full, bit1 empty, bit2 busy, bit3 overflow, bits[11:8] FIFO count (0..FIFO_DEPTH), all other bits 0.
  - Reflects register state before the current edge.
- Reads: rdata for TXDATA (addr[2]=0) is 0; rdata is 0 when sel=0.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty at edge, pop into shift register, go to START, tx<=0. A byte pushed at E therefore drives tx low from edge E+1.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then tx<=shift[0], go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. After bit 7, tx<=1 and go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the final cycle, if FIFO non-empty, pop and go directly to START with tx<=0 (no idle gap); else go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit counter 0..7; both reset on every state entry.
  - Counter widths are $clog2-derived; no wrap beyond terminal count.
- busy = (state != IDLE) | ~empty, combinational from registers.
- Pop and push in the same cycle are both legal at any occupancy.
- FIFO pointers wrap modulo FIFO_DEPTH; count is a separate register or derived with one extra bit.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/STOP);
  - register offsets TXDATA_OFS=0, STATUS_OFS=4;
  - status bit indices (FULL=0, EMPTY=1, BUSY=2, OVF=3, COUNT_LSB=8).
- One sub-module, sync_fifo: width 8, depth FIFO_DEPTH, push/pop/full/empty/count, synchronous reset on clk/rst.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
- Reset, then read STATUS -> rdata=32'h0000_0002, tx=1, busy=0.
- Store 0x55 to TXDATA at edge E:
  - tx=0 for cycles E+1..E+4, then 1,0,1,0,1,0,1,0 (4 cycles each), then stop 1 for 4 cycles.
  - busy falls after 40 cycles.
- Store 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous frames totalling 120 cycles, no idle-high gap between stop and next start, bytes in order.
- Store 10 bytes on 10 consecutive cycles:
  - 9 accepted (1 popped at E+1, 8 queued), 10th dropped.
  - STATUS reads 0x0000_080D (count 8, full, busy, ovf).
  - 9 frames emitted.
  - A store to STATUS then clears bit3.
- Assert rst during DATA of a frame:
  - tx=1 at the next edge;
  - STATUS=0x0000_0002;
  - no further frames even though bytes were queued.
- Store with sel=0 and with mem_write=0 -> FIFO unchanged, tx stays 1, rdata=0 when sel=0.
